// File: rtl/synth_pkg.sv
// synth_pkg: definitions shared by the synth oscillator core and the SPI register bank.
//   CTRL_*   bit indices into reg_control
//   FREQ_W   frequency word width
//   SAMPLE_W audio sample width
//   SUM_W    width of the mixed-waveform sum (max 3 x 255 = 765)
//   PROD_W   width of sum x volume
//   ctrl_t   control bits latched at each sample tick
package synth_pkg;

  localparam int CTRL_OSC_EN  = 0;
  localparam int CTRL_SW_GATE = 1;
  localparam int CTRL_SQ_EN   = 2;
  localparam int CTRL_SAW_EN  = 3;
  localparam int CTRL_TRI_EN  = 4;

  localparam int FREQ_W   = 24;
  localparam int SAMPLE_W = 8;
  localparam int SUM_W    = 10;
  localparam int PROD_W   = SUM_W + SAMPLE_W;

  typedef struct packed {
    logic tri_en;
    logic saw_en;
    logic sq_en;
    logic sw_gate;
    logic osc_en;
  } ctrl_t;

endpackage

// File: rtl/synth_pwm_dac.sv
// synth_pwm_dac: 8-bit PWM DAC. It is built only when SYNTH_PWM_OUT_EN is defined.
//   clk, rst_n  system clock and asynchronous active-low reset
//   i_level     sample level to convert
//   o_pwm       high for i_level clocks out of every 256
// The level is reloaded only when the counter wraps. This keeps each PWM period
// internally consistent, so no runt pulses occur.
`ifdef SYNTH_PWM_OUT_EN
import synth_pkg::*;

module synth_pwm_dac (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] i_level,
  output logic                o_pwm
);

  logic [SAMPLE_W-1:0] r_cnt;
  logic [SAMPLE_W-1:0] r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= '0;
    end else begin
      r_cnt <= r_cnt + SAMPLE_W'(1);
      if (r_cnt == '1) r_level <= i_level;
    end
  end

  assign o_pwm = (r_cnt < r_level);

endmodule
`endif

// File: rtl/synth_osc_core.sv
// synth_osc_core: sample-rate oscillator and mixer that sits after the SPI register bank.
//   clk, rst_n            system clock and asynchronous active-low reset
//   reg_control           b0 OSC_EN, b1 SW_GATE, b2 SQ_EN, b3 SAW_EN, b4 TRI_EN
//   reg_freq_low/mid/high 24-bit phase increment per sample tick
//   reg_duty              square-wave threshold on phase[23:16]
//   reg_volume            linear master volume
//   sample_out            mixed, volume-scaled sample
//   sample_valid          one-clock pulse when sample_out updates
//   status_osc_running    OSC_EN registered at the tick
//   status_gate_active    OSC_EN & SW_GATE registered at the tick
//   pwm_out               PWM DAC of sample_out. Enabled by the SYNTH_PWM_OUT_EN macro; tied 0 otherwise.
// Pipeline for tick T:
//   T    phase update, control latch
//   T+1  waveform sum
//   T+2  volume scale, gate, sample_valid
import synth_pkg::*;

module synth_osc_core #(
  parameter int SAMPLE_DIV = 1024,
  parameter int PHASE_W    = FREQ_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          reg_control,
  input  logic [7:0]          reg_freq_low,
  input  logic [7:0]          reg_freq_mid,
  input  logic [7:0]          reg_freq_high,
  input  logic [7:0]          reg_duty,
  input  logic [7:0]          reg_volume,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                status_osc_running,
  output logic                status_gate_active,
  output logic                pwm_out
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [PHASE_W-1:0]  r_phase;
  logic [FREQ_W-1:0]   r_freq_active;
  logic [FREQ_W-1:0]   r_freq_cand;
  ctrl_t               r_ctrl0;
  logic                r_osc_running;
  logic                r_gate_active;
  logic                r_v0;
  logic                r_v1;
  logic                r_valid;
  logic [SUM_W-1:0]    r_sum;
  logic [SAMPLE_W-1:0] r_sample;

  logic                w_tick;
  logic [FREQ_W-1:0]   w_freq_raw;
  ctrl_t               w_ctrl;
  logic [7:0]          w_ph8;
  logic [7:0]          w_sq;
  logic [7:0]          w_tri;
  logic [SUM_W-1:0]    w_sum;
  logic [SAMPLE_W-1:0] w_scaled;
  logic                w_ctrl_unused;

  assign w_tick        = (r_div_cnt == DIV_LAST);
  assign w_freq_raw    = {reg_freq_high, reg_freq_mid, reg_freq_low};
  assign w_ctrl_unused = ^reg_control[7:5];
  assign w_ctrl        = '{tri_en:  reg_control[CTRL_TRI_EN],
                           saw_en:  reg_control[CTRL_SAW_EN],
                           sq_en:   reg_control[CTRL_SQ_EN],
                           sw_gate: reg_control[CTRL_SW_GATE],
                           osc_en:  reg_control[CTRL_OSC_EN]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  // A frequency word is adopted only after it has been seen unchanged on two
  // consecutive ticks. A half-written multi-byte update is therefore never used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_freq_active <= '0;
      r_freq_cand   <= '0;
      r_ctrl0       <= '0;
      r_osc_running <= 1'b0;
      r_gate_active <= 1'b0;
    end else if (w_tick) begin
      r_phase       <= w_ctrl.osc_en ? r_phase + PHASE_W'(r_freq_active) : '0;
      r_freq_cand   <= w_freq_raw;
      if (w_freq_raw == r_freq_cand) r_freq_active <= w_freq_raw;
      r_ctrl0       <= w_ctrl;
      r_osc_running <= w_ctrl.osc_en;
      r_gate_active <= w_ctrl.osc_en & w_ctrl.sw_gate;
    end
  end

  assign w_ph8 = r_phase[PHASE_W-1 -: 8];
  assign w_sq  = (w_ph8 < reg_duty) ? 8'hFF : 8'h00;
  assign w_tri = r_phase[PHASE_W-1] ? ~r_phase[PHASE_W-2 -: 8] : r_phase[PHASE_W-2 -: 8];

  always_comb begin
    w_sum = '0;
    if (r_ctrl0.sq_en)  w_sum = w_sum + SUM_W'(w_sq);
    if (r_ctrl0.saw_en) w_sum = w_sum + SUM_W'(w_ph8);
    if (r_ctrl0.tri_en) w_sum = w_sum + SUM_W'(w_tri);
  end

  assign w_scaled = SAMPLE_W'((PROD_W'(r_sum) * PROD_W'(reg_volume)) >> (PROD_W - SAMPLE_W));

  // r_ctrl0 is held from tick T until the next tick, which comes SAMPLE_DIV clocks
  // later (at least 4). The gate applied at T+2 therefore matches the control
  // that produced this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_sample <= '0;
    end else begin
      r_v0    <= w_tick;
      r_v1    <= r_v0;
      r_valid <= r_v1;
      if (r_v0) r_sum <= w_sum;
      if (r_v1) r_sample <= (r_ctrl0.osc_en & r_ctrl0.sw_gate) ? w_scaled : '0;
    end
  end

  assign sample_out         = r_sample;
  assign sample_valid       = r_valid;
  assign status_osc_running = r_osc_running;
  assign status_gate_active = r_gate_active;

`ifdef SYNTH_PWM_OUT_EN
  synth_pwm_dac u_pwm_dac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (r_sample),
    .o_pwm   (pwm_out)
  );
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_synth_osc_core.sv
module tb_synth_osc_core;

  localparam int SDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] reg_control = '0, reg_freq_low = '0, reg_freq_mid = '0, reg_freq_high = '0;
  logic [7:0] reg_duty = '0, reg_volume = '0;
  logic [7:0] sample_out;
  logic       sample_valid, status_osc_running, status_gate_active, pwm_out;

  always #5 clk = ~clk;

  synth_osc_core #(.SAMPLE_DIV(SDIV)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .reg_control        (reg_control),
    .reg_freq_low       (reg_freq_low),
    .reg_freq_mid       (reg_freq_mid),
    .reg_freq_high      (reg_freq_high),
    .reg_duty           (reg_duty),
    .reg_volume         (reg_volume),
    .sample_out         (sample_out),
    .sample_valid       (sample_valid),
    .status_osc_running (status_osc_running),
    .status_gate_active (status_gate_active),
    .pwm_out            (pwm_out)
  );

  typedef struct {
    int         edge_i;
    logic [7:0] smp;
    logic       osc;
    logic       gate;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_idx = 0;
  logic [23:0] m_phase = '0, m_fact = '0, m_fcand = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the sample value for a given phase and control setting, from the waveform and mix rules.
  function automatic logic [7:0] model_sample(input logic [23:0] ph, input logic [7:0] c,
                                              input logic [7:0] d, input logic [7:0] v);
    int p8, t8, tri_v, sum;
    p8    = int'(ph[23:16]);
    t8    = int'(ph[22:15]);
    tri_v = ph[23] ? 255 - t8 : t8;
    sum   = 0;
    if (c[2]) sum += (p8 < int'(d)) ? 255 : 0;
    if (c[3]) sum += p8;
    if (c[4]) sum += tri_v;
    if (!(c[0] && c[1])) return 8'h00;
    return 8'((sum * int'(v)) >> 10);
  endfunction

  // Tick-level model. A tick happens on every SDIV-th clock edge after reset.
  // The sample for that tick is due two edges later.
  always @(posedge clk or negedge rst_n) begin
    logic [23:0] raw;
    exp_t        e;
    if (!rst_n) begin
      edge_idx = 0;
      m_phase  = '0;
      m_fact   = '0;
      m_fcand  = '0;
      q.delete();
    end else begin
      if (edge_idx % SDIV == SDIV - 1) begin
        raw     = {reg_freq_high, reg_freq_mid, reg_freq_low};
        m_phase = reg_control[0] ? m_phase + m_fact : 24'h0;
        if (raw == m_fcand) m_fact = raw;
        m_fcand  = raw;
        e.edge_i = edge_idx + 2;
        e.smp    = model_sample(m_phase, reg_control, reg_duty, reg_volume);
        e.osc    = reg_control[0];
        e.gate   = reg_control[0] & reg_control[1];
        q.push_back(e);
      end
      edge_idx++;
    end
  end

  // Monitor: compares the DUT against the model each time sample_valid is seen.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sample_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 32'(sample_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("valid_timing", 32'(edge_idx - 1), 32'(e.edge_i));
            chk("sample", 32'(sample_out), 32'(e.smp));
            chk("osc_running", 32'(status_osc_running), 32'(e.osc));
            chk("gate_active", 32'(status_gate_active), 32'(e.gate));
`ifndef SYNTH_PWM_OUT_EN
            chk("pwm_tied_low", 32'(pwm_out), 32'd0);
`endif
          end
        end else if (q.size() > 0 && q[0].edge_i <= edge_idx - 1) begin
          e = q.pop_front();
          chk("missing_valid", 32'(sample_valid), 32'd1);
        end
      end
    end
  end

  task automatic apply(input logic [7:0] c, input logic [23:0] f, input logic [7:0] d, input logic [7:0] v);
    reg_control = c;
    {reg_freq_high, reg_freq_mid, reg_freq_low} = f;
    reg_duty = d;
    reg_volume = v;
  endtask

  task automatic run(input int periods);
    repeat (periods * SDIV) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_osc", 32'(status_osc_running), 32'd0);
    chk("rst_gate", 32'(status_gate_active), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
  endtask

`ifdef SYNTH_PWM_OUT_EN
  task automatic pwm_count(input int exp_hi);
    int hi;
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("pwm_high_count", 32'(hi), 32'(exp_hi));
  endtask
`endif

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // All waveforms on, 0x010000 per tick.
    apply(8'h1F, 24'h010000, 8'h80, 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(6);

    // Sawtooth only. The phase sweeps through 0x80xxxx, where the expected sample is 31.
    apply(8'h0B, 24'h010000, 8'h80, 8'hFF);
    run(140);

    // Torn update: the mid byte changes for one tick only, then the word settles on 0x020000.
    apply(8'h1B, 24'h000000, 8'h40, 8'hFF);
    run(3);
    reg_freq_mid = 8'h80;
    run(1);
    reg_freq_high = 8'h02;
    reg_freq_mid  = 8'h00;
    run(6);

    // Maximum frequency: the phase wraps every tick. Then the oscillator is disabled.
    apply(8'h1F, 24'hFFFFFF, 8'hC0, 8'hA0);
    run(6);
    apply(8'h1E, 24'hFFFFFF, 8'hC0, 8'hA0);
    run(3);

    // Gate closed while the phase keeps running, then reopened.
    apply(8'h1D, 24'h030000, 8'h80, 8'hFF);
    run(4);
    apply(8'h1F, 24'h030000, 8'h80, 8'hFF);
    run(4);

    // Reset in the middle of the pipeline.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(4);

    // Randomised operation.
    for (int i = 0; i < 200; i++) begin
      logic [7:0]  c;
      logic [23:0] f;
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) c[1:0] = 2'b11;
      f = {reg_freq_high, reg_freq_mid, reg_freq_low};
      if ($urandom_range(0, 2) == 0) f = 24'($urandom);
      apply(c, f, 8'($urandom), 8'($urandom));
      run($urandom_range(1, 3));
    end

`ifdef SYNTH_PWM_OUT_EN
    // Phase zeroed, then the square wave alone at full volume gives sample (255*255)>>10 = 63.
    apply(8'h06, 24'h000000, 8'h80, 8'hFF);
    run(4);
    apply(8'h07, 24'h000000, 8'h80, 8'hFF);
    run(160);
    pwm_count(63);
    apply(8'h07, 24'h000000, 8'h80, 8'h00);
    run(160);
    pwm_count(0);
`endif

    run(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
